// File: rtl/program_sequencer.sv
// Host-side program sequencer: issues stored instructions to the CPU one at
// a time, samples each result after a settle delay, and keeps a checksum.
module program_sequencer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int RESULT_WAIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_wdata,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  output logic [7:0]        instruction,
  input  logic [7:0]        cpu_result,
  output logic              busy,
  output logic              res_valid,
  output logic [7:0]        res_data,
  output logic [ADDR_W-1:0] res_index,
  output logic [7:0]        checksum,
  output logic              done
);

  localparam int WW = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [WW-1:0]   WAIT_L  = WW'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, FINISH
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W:0]   len;
  logic [WW-1:0]     wcnt;
  logic              last;

  assign last = ({1'b0, pc} == len - 1'b1);
  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE)
      mem[prog_addr] <= prog_wdata;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (start)
          state_nx = (prog_len != '0) ? ISSUE : FINISH;
      ISSUE:   state_nx = WAIT;
      WAIT:
        if (wcnt == '0)
          state_nx = CAPTURE;
      CAPTURE: state_nx = last ? FINISH : ISSUE;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= '0;
      len         <= '0;
      wcnt        <= '0;
      instruction <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_index   <= '0;
      checksum    <= '0;
    end else begin
      state     <= state_nx;
      res_valid <= (state == CAPTURE);
      unique case (state)
        IDLE:
          if (start) begin
            checksum <= '0;
            pc       <= '0;
            // pc stays inside the memory even for oversized requests
            len      <= (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
          end
        ISSUE: begin
          instruction <= mem[pc];
          wcnt        <= WAIT_L;
        end
        WAIT:
          if (wcnt != '0)
            wcnt <= wcnt - 1'b1;
        CAPTURE: begin
          res_data  <= cpu_result;
          res_index <= pc;
          checksum  <= checksum + cpu_result;
          if (!last)
            pc <= pc + 1'b1;
        end
        FINISH: instruction <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Randomized bench for program_sequencer with a timeline-based reference
// model, plus literal expectations for the classic scenarios.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RW    = 1;
  localparam int P     = 2 + RW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [7:0]    prog_wdata = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic [7:0]    instruction;
  logic [7:0]    cpu_result;
  logic          busy, res_valid, done;
  logic [7:0]    res_data, checksum;
  logic [AW-1:0] res_index;

  always #5 clk = ~clk;

  // CPU stand-in: result is instruction + 1
  assign cpu_result = instruction + 8'd1;

  program_sequencer #(
    .DEPTH(DEPTH), .ADDR_W(AW), .RESULT_WAIT(RW)
  ) dut (
    .clk(clk), .reset(reset),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len),
    .start(start), .instruction(instruction),
    .cpu_result(cpu_result), .busy(busy),
    .res_valid(res_valid), .res_data(res_data),
    .res_index(res_index), .checksum(checksum),
    .done(done)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a run is (start edge t0, length L, program snapshot).
  logic [7:0] mmem [DEPTH];
  logic [7:0] rmem [DEPTH];
  bit         have_run = 0;
  int         t0 = 0;
  int         rl = 0;
  int         cyc = 0;

  function automatic bit model_busy();
    return have_run && (cyc - t0) <= P * rl;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_run <= 0;
    end else begin
      cyc <= cyc + 1;
      if (!model_busy() && prog_we)
        mmem[prog_addr] <= prog_wdata;
      if (!model_busy() && start) begin
        have_run <= 1;
        t0       <= cyc + 1;
        rl       <= (int'(prog_len) > DEPTH) ? DEPTH
                                             : int'(prog_len);
        for (int i = 0; i < DEPTH; i++)
          rmem[i] <= (prog_we && int'(prog_addr) == i)
                     ? prog_wdata : mmem[i];
      end
    end
  end

  typedef struct { int idx; int data; } ev_t;
  ev_t vq[$];
  int  done_cnt = 0;
  int  done_rel = 0;

  always @(negedge clk) begin : cmp
    int rel, n;
    logic [7:0] e_cs, e_ins;
    bit e_busy, e_done, e_val;
    if (reset) begin
      rel    = cyc - t0;
      e_busy = have_run && rel <= P * rl;
      e_done = have_run && rel == P * rl;
      e_val  = have_run && rel >= P && rel % P == 0
               && rel / P <= rl;
      n = have_run ? ((rel / P < rl) ? rel / P : rl) : 0;
      e_cs = 8'd0;
      for (int k = 0; k < n; k++)
        e_cs = e_cs + rmem[k] + 8'd1;
      e_ins = (have_run && rel >= 1 && rel <= P * rl)
              ? rmem[(rel - 1) / P] : 8'd0;
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("res_valid", 32'(res_valid), 32'(e_val));
      chk("instruction", 32'(instruction), 32'(e_ins));
      chk("checksum", 32'(checksum), 32'(e_cs));
      if (e_val) begin
        chk("res_index", 32'(res_index), 32'(rel / P - 1));
        chk("res_data", 32'(res_data),
            32'(rmem[rel / P - 1] + 8'd1));
      end
      if (res_valid)
        vq.push_back('{int'(res_index), int'(res_data)});
      if (done) begin
        done_cnt++;
        done_rel = rel + 1;
      end
    end
  end

  task automatic wr(int a, logic [7:0] d);
    @(negedge clk);
    prog_we = 1; prog_addr = AW'(a); prog_wdata = d;
    @(negedge clk);
    prog_we = 0;
  endtask

  task automatic go(int l);
    vq.delete();
    done_cnt = 0;
    @(negedge clk);
    start = 1; prog_len = (AW+1)'(l);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 32'(1), 32'(0));
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #1;
    chk("rst_instr", 32'(instruction), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_valid", 32'(res_valid), 32'(0));
    chk("rst_data", 32'(res_data), 32'(0));
    chk("rst_index", 32'(res_index), 32'(0));
    chk("rst_cs", 32'(checksum), 32'(0));
    @(negedge clk);
    chk("rst_done_hold", 32'(done), 32'(0));
    #2 reset = 1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("init_busy", 32'(busy), 32'(0));
    chk("init_cs", 32'(checksum), 32'(0));
    #2 reset = 1;
    for (int i = 0; i < DEPTH; i++) wr(i, 8'(i * 7));

    // Basic three-instruction program
    wr(0, 8'h10); wr(1, 8'h24); wr(2, 8'h31);
    go(3);
    wait_idle();
    chk("t2_npulse", 32'(vq.size()), 32'(3));
    if (vq.size() == 3) begin
      chk("t2_i0", 32'(vq[0].data), 32'h11);
      chk("t2_i1", 32'(vq[1].data), 32'h25);
      chk("t2_i2", 32'(vq[2].data), 32'h32);
      chk("t2_x2", 32'(vq[2].idx), 32'd2);
    end
    chk("t2_cs", 32'(checksum), 32'h68);
    chk("t2_done_at", 32'(done_rel), 32'd10);
    chk("t2_done_cnt", 32'(done_cnt), 32'd1);

    // Checksum wraps mod 256
    wr(0, 8'hEF); wr(1, 8'h1F);
    go(2);
    wait_idle();
    chk("t3_cs", 32'(checksum), 32'h10);

    // Empty run
    go(0);
    wait_idle();
    chk("t4_npulse", 32'(vq.size()), 32'(0));
    chk("t4_cs", 32'(checksum), 32'(0));
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Start and write while busy are dropped
    wr(0, 8'h10); wr(1, 8'h24); wr(2, 8'h31);
    go(3);
    @(negedge clk);
    start = 1; prog_len = 5'd1;
    prog_we = 1; prog_addr = '0; prog_wdata = 8'hFF;
    @(negedge clk);
    start = 0; prog_we = 0;
    wait_idle();
    chk("t5_npulse", 32'(vq.size()), 32'(3));
    chk("t5_cs", 32'(checksum), 32'h68);
    go(1);
    wait_idle();
    if (vq.size() == 1)
      chk("t5_mem0", 32'(vq[0].data), 32'h11);
    else
      chk("t5_npulse2", 32'(vq.size()), 32'(1));

    // Oversized length clamps to DEPTH
    go(17);
    wait_idle();
    chk("t6_npulse", 32'(vq.size()), 32'(16));
    if (vq.size() == 16)
      chk("t6_last_idx", 32'(vq[15].idx), 32'd15);

    // Reset in the middle of a run, in WAIT
    go(5);
    repeat (4) @(negedge clk);
    do_reset();
    chk("t1_cs_after", 32'(checksum), 32'(0));

    // Randomized runs
    for (int it = 0; it < 30; it++) begin
      int nw, l, gap;
      nw = $urandom_range(0, 6);
      for (int j = 0; j < nw; j++)
        wr($urandom_range(0, DEPTH - 1), 8'($urandom));
      l = $urandom_range(0, 17);
      go(l);
      gap = $urandom_range(0, 3 * l + 2);
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        start = ($urandom_range(0, 3) == 0);
        prog_len = 5'($urandom_range(0, 17));
        prog_we = ($urandom_range(0, 2) == 0);
        prog_addr = AW'($urandom);
        prog_wdata = 8'($urandom);
      end
      @(negedge clk);
      start = 0; prog_we = 0;
      if ($urandom_range(0, 7) == 0 && busy) do_reset();
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
